core_launch_master: RTL



---
 rtl/core_ctrl_pkg.sv | 27 ++
 rtl/axi_lite_single_xfer.sv | 81 ++++++++
 rtl/core_launch_master.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller register block and its launch master.
package core_ctrl_pkg;

    localparam logic [7:0] REG_RST   = 8'h00;
    localparam logic [7:0] REG_EXEC  = 8'h04;
    localparam logic [7:0] REG_MADDR = 8'h08;
    localparam logic [7:0] REG_STAT  = 8'h0C;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_RST1,
        ST_W_MADDR,
        ST_W_RST0,
        ST_W_EXEC1,
        ST_GAP,
        ST_R_STAT,
        ST_W_EXEC0
    } launch_state_t;

    // States that own a bus transaction; GAP and IDLE never touch the bus.
    function automatic logic is_xfer_state(input launch_state_t s);
        return !((s == ST_IDLE) || (s == ST_GAP));
    endfunction

endpackage

// File: rtl/axi_lite_single_xfer.sv
// One-transaction AXI4-Lite write/read engine. A req is accepted only while
// idle or in the same cycle as the previous transaction's ack, so at most one
// transaction is ever outstanding. ack/rdata/resp_err are valid for the single
// cycle of the B or R handshake.
import core_ctrl_pkg::*;

module axi_lite_single_xfer #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req,
    input  logic            i_we,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic            o_ack,
    output logic [DW-1:0]   o_rdata,
    output logic            o_resp_err,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY,
    output logic [AW-1:0]   M_AXI_ARADDR,
    output logic            M_AXI_ARVALID,
    input  logic            M_AXI_ARREADY,
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY
);

    logic w_b_hs;
    logic w_r_hs;

    assign w_b_hs     = M_AXI_BVALID & M_AXI_BREADY;
    assign w_r_hs     = M_AXI_RVALID & M_AXI_RREADY;
    assign o_ack      = w_b_hs | w_r_hs;
    assign o_rdata    = M_AXI_RDATA;
    assign o_resp_err = (w_b_hs && (M_AXI_BRESP != RESP_OKAY)) ||
                        (w_r_hs && (M_AXI_RRESP != RESP_OKAY));

    // Channel handshakes; a new request issued on the ack cycle overrides the clears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
            if (w_b_hs) M_AXI_BREADY <= 1'b0;
            if (w_r_hs) M_AXI_RREADY <= 1'b0;
            if (i_req) begin
                if (i_we) begin
                    M_AXI_AWADDR  <= i_addr;
                    M_AXI_WDATA   <= i_wdata;
                    M_AXI_AWVALID <= 1'b1;
                    M_AXI_WVALID  <= 1'b1;
                    M_AXI_BREADY  <= 1'b1;
                end else begin
                    M_AXI_ARADDR  <= i_addr;
                    M_AXI_ARVALID <= 1'b1;
                    M_AXI_RREADY  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/core_launch_master.sv
// AXI4-Lite master running the core launch sequence from a single start pulse.
// Optional macro CORE_LAUNCH_TIMEOUT_EN: abort polling after C_TIMEOUT_POLLS status reads.
//
// state      | meaning
// IDLE       | waiting for start
// W_RST1     | writing RST = 1
// W_MADDR    | writing program start address
// W_RST0     | writing RST = 0
// W_EXEC1    | writing EXEC = 1
// GAP        | idle cycles before each status read
// R_STAT     | reading STAT, bit 0 = core finished
// W_EXEC0    | writing EXEC = 0 (also the abort path after an error)
import core_ctrl_pkg::*;

module core_launch_master #(
    parameter int                          C_M_AXI_ADDR_WIDTH = 16,
    parameter int                          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = '0,
    parameter int                          C_POLL_GAP         = 16,
    parameter int                          C_TIMEOUT_POLLS    = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              start,
    input  logic [31:0]                       mem_addr,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [15:0] LP_GAP_LOAD = 16'(C_POLL_GAP - 1);

    launch_state_t r_state, w_state_nxt;
    logic [31:0]   r_mem_addr;
    logic [15:0]   r_gap_cnt;
    logic          r_done, r_err;
    logic          w_req, w_we, w_ack, w_resp_err;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata, w_rdata;
    logic          w_err_set, w_done_set, w_start_acc, w_timeout;
    logic          w_unused_rdata;

    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_WSTRB    = '1;
    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;
    assign err            = r_err;
    assign w_unused_rdata = ^w_rdata[DW-1:1];

    // The done cycle is already IDLE, so start is additionally blocked there.
    assign w_start_acc = (r_state == ST_IDLE) && start && !r_done;

`ifdef CORE_LAUNCH_TIMEOUT_EN
    logic [15:0] r_poll_cnt;
    assign w_timeout = ((r_poll_cnt + 16'd1) == 16'(C_TIMEOUT_POLLS));

    // Status reads issued since the accepted start.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN)                   r_poll_cnt <= '0;
        else if (w_start_acc)                 r_poll_cnt <= '0;
        else if (r_state == ST_R_STAT && w_ack) r_poll_cnt <= r_poll_cnt + 16'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State, status flags, latched address and gap down-counter.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state    <= ST_IDLE;
            r_mem_addr <= '0;
            r_gap_cnt  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_set;
            if (w_start_acc) begin
                r_err      <= 1'b0;
                r_mem_addr <= mem_addr;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_state_nxt == ST_GAP && r_state != ST_GAP)
                r_gap_cnt <= LP_GAP_LOAD;
            else if (r_state == ST_GAP && r_gap_cnt != 16'd0)
                r_gap_cnt <= r_gap_cnt - 16'd1;
        end
    end

    // Next state; any bad response diverts to the single EXEC = 0 attempt.
    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            ST_IDLE:    if (w_start_acc) w_state_nxt = ST_W_RST1;
            ST_W_RST1, ST_W_MADDR, ST_W_RST0, ST_W_EXEC1: begin
                if (w_ack) begin
                    if (w_resp_err) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_W_EXEC0;
                    end else begin
                        case (r_state)
                            ST_W_RST1:  w_state_nxt = ST_W_MADDR;
                            ST_W_MADDR: w_state_nxt = ST_W_RST0;
                            ST_W_RST0:  w_state_nxt = ST_W_EXEC1;
                            default:    w_state_nxt = ST_GAP;
                        endcase
                    end
                end
            end
            ST_GAP:     if (r_gap_cnt == 16'd0) w_state_nxt = ST_R_STAT;
            ST_R_STAT: begin
                if (w_ack) begin
                    if (w_resp_err || (!w_rdata[0] && w_timeout)) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_W_EXEC0;
                    end else if (w_rdata[0]) begin
                        w_state_nxt = ST_W_EXEC0;
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_W_EXEC0: begin
                if (w_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_err_set   = w_resp_err;
                    w_done_set  = !w_resp_err && !r_err;
                end
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Transaction issued on entry to each bus state, so it leaves on the transition edge.
    always_comb begin
        w_we    = 1'b1;
        w_addr  = C_BASE_ADDR + AW'(REG_RST);
        w_wdata = '0;
        case (w_state_nxt)
            ST_W_RST1:  w_wdata = DW'(1);
            ST_W_MADDR: begin
                w_addr  = C_BASE_ADDR + AW'(REG_MADDR);
                w_wdata = DW'(r_mem_addr);
            end
            ST_W_EXEC1: begin
                w_addr  = C_BASE_ADDR + AW'(REG_EXEC);
                w_wdata = DW'(1);
            end
            ST_W_EXEC0: w_addr = C_BASE_ADDR + AW'(REG_EXEC);
            ST_R_STAT: begin
                w_we   = 1'b0;
                w_addr = C_BASE_ADDR + AW'(REG_STAT);
            end
            default: ;
        endcase
        w_req = (w_state_nxt != r_state) && is_xfer_state(w_state_nxt);
    end

    axi_lite_single_xfer #(.AW(AW), .DW(DW)) u_xfer (
        .i_clk         (M_AXI_ACLK),
        .i_rst_n       (M_AXI_ARESETN),
        .i_req         (w_req),
        .i_we          (w_we),
        .i_addr        (w_addr),
        .i_wdata       (w_wdata),
        .o_ack         (w_ack),
        .o_rdata       (w_rdata),
        .o_resp_err    (w_resp_err),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

endmodule
